// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the data memory controller and its load aligner:
//   - access size encodings (SZ_B/SZ_H/SZ_W/SZ_D)
//   - controller FSM state type
//   - helpers for the size alignment mask and the store byte-enable mask
// No ports (package).
// -----------------------------------------------------------------------------
package data_mem_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // Low address bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] size_lsb_mask(input logic [1:0] size);
      logic [2:0] m;
      case (size)
         SZ_B:    m = 3'b000;
         SZ_H:    m = 3'b001;
         SZ_W:    m = 3'b011;
         default: m = 3'b111;
      endcase
      return m;
   endfunction

   // Byte enables for an access of 'size' starting at byte lane 'off'
   // within a 64-bit word; narrower words use the low lanes only.
   function automatic logic [7:0] byte_en(input logic [1:0] size,
                                          input logic [2:0] off);
      logic [7:0] base;
      case (size)
         SZ_B:    base = 8'h01;
         SZ_H:    base = 8'h03;
         SZ_W:    base = 8'h0F;
         default: base = 8'hFF;
      endcase
      return base << off;
   endfunction

endpackage

// File: rtl/data_mem_load_align.sv
// -----------------------------------------------------------------------------
// data_mem_load_align
// Combinational load alignment: extracts the size-wide field at the given
// byte lane of a memory word and sign- or zero-extends it to BITS.
// A double access returns the whole word.
// Ports:
//   word_i      memory word (BITS)
//   size_i      access size (SZ_B/SZ_H/SZ_W/SZ_D)
//   off_i       byte lane offset of the field
//   unsigned_i  1 = zero-extend, 0 = sign-extend
//   data_o      extended load data (BITS)
// -----------------------------------------------------------------------------
module data_mem_load_align
   import data_mem_pkg::*;
#(
   parameter int BITS  = 64,
   parameter int OFF_W = $clog2(BITS/8)
) (
   input  logic [BITS-1:0]  word_i,
   input  logic [1:0]       size_i,
   input  logic [OFF_W-1:0] off_i,
   input  logic             unsigned_i,
   output logic [BITS-1:0]  data_o
);

   // Only up to a word is ever extracted by shifting; doubles bypass this.
   logic [31:0] sh;
   assign sh = 32'(word_i >> {off_i, 3'b000});

   always_comb begin
      data_o = word_i;
      case (size_i)
         SZ_B: data_o = unsigned_i ? BITS'(sh[7:0])  : BITS'($signed(sh[7:0]));
         SZ_H: data_o = unsigned_i ? BITS'(sh[15:0]) : BITS'($signed(sh[15:0]));
         SZ_W: data_o = unsigned_i ? BITS'(sh[31:0]) : BITS'($signed(sh[31:0]));
         default: data_o = word_i;
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Byte-addressed data memory for the load/store unit. One outstanding request;
// valid/ready on both request and response; fixed LATENCY from acceptance to
// resp_valid_o. Stores merge into the array by byte enable at the accept edge;
// loads sample the word at the accept edge into a holding register.
//
// Build option DMEM_MISALIGN_CHECK_EN:
//   defined   - non size-aligned addresses return resp_err_o=1, no write, rdata 0
//   undefined - lane offset is masked down to the size boundary and the
//               access proceeds; resp_err_o flags only the illegal size
//               (double on a 32-bit memory).
//
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   req_valid_i/ready_o   request handshake
//   req_we_i              1 = store, 0 = load
//   req_addr_i            byte address
//   req_size_i            00 byte, 01 half, 10 word, 11 double
//   req_unsigned_i        loads: 1 = zero-extend
//   req_wdata_i           store data, LSB aligned
//   resp_valid_o/ready_i  response handshake
//   resp_rdata_o          extended load data, 0 for stores and errors
//   resp_err_o            illegal size (or misaligned, when checked)
// -----------------------------------------------------------------------------
module data_mem_ctrl
   import data_mem_pkg::*;
#(
   parameter int BITS      = 64,
   parameter int DEPTH     = 32,
   parameter int LATENCY   = 1,
   parameter int ADDR_BITS = $clog2(DEPTH*BITS/8)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [ADDR_BITS-1:0] req_addr_i,
   input  logic [1:0]           req_size_i,
   input  logic                 req_unsigned_i,
   input  logic [BITS-1:0]      req_wdata_i,
   output logic                 resp_valid_o,
   input  logic                 resp_ready_i,
   output logic [BITS-1:0]      resp_rdata_o,
   output logic                 resp_err_o
);

   localparam int NB    = BITS/8;
   localparam int OFF   = $clog2(NB);
   localparam int CNT_W = $clog2(LATENCY+1);

   logic [BITS-1:0] mem_q [DEPTH];

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             we_q, uns_q, err_q;
   logic [1:0]       size_q;
   logic [OFF-1:0]   off_q;
   logic [BITS-1:0]  hold_q;
   logic             req_ready_q, resp_valid_q, resp_err_q;
   logic [BITS-1:0]  resp_rdata_q;

   // ---------------- request decode ----------------
   logic [ADDR_BITS-OFF-1:0] idx;
   logic [2:0]               off3, off3_eff;
   logic [OFF-1:0]           off_eff;
   logic                     ill_size, misal, err_d, accept;

   assign idx      = req_addr_i[ADDR_BITS-1:OFF];
   assign off3     = 3'(req_addr_i[OFF-1:0]);
   assign off3_eff = off3 & ~size_lsb_mask(req_size_i);
   assign off_eff  = off3_eff[OFF-1:0];
   assign ill_size = (req_size_i == SZ_D) && (BITS == 32);
`ifdef DMEM_MISALIGN_CHECK_EN
   assign misal    = |(off3 & size_lsb_mask(req_size_i));
`else
   assign misal    = 1'b0;
`endif
   assign err_d    = ill_size | misal;
   assign accept   = req_valid_i & req_ready_q;

   // ---------------- store merge ----------------
   logic [NB-1:0]   be;
   logic [BITS-1:0] wdata_sh, rd_word, word_d;

   assign be       = NB'(byte_en(req_size_i, off3_eff));
   assign wdata_sh = req_wdata_i << {off_eff, 3'b000};
   assign rd_word  = mem_q[idx];

   always_comb begin
      word_d = rd_word;
      for (int b = 0; b < NB; b++)
         if (be[b]) word_d[8*b +: 8] = wdata_sh[8*b +: 8];
   end

   // Array is not reset; a store committed here survives a later reset.
   always_ff @(posedge clk_i) begin
      if (accept && req_we_i && !err_d) mem_q[idx] <= word_d;
   end

   // ---------------- load alignment ----------------
   // In IDLE the aligner sees the live request so LATENCY=1 can register
   // the response at the accept edge; afterwards it sees the latched copy.
   logic            in_idle;
   logic [BITS-1:0] al_word, load_val;
   logic [1:0]      al_size;
   logic [OFF-1:0]  al_off;
   logic            al_uns;

   assign in_idle = (state_q == IDLE);
   assign al_word = in_idle ? rd_word        : hold_q;
   assign al_size = in_idle ? req_size_i     : size_q;
   assign al_off  = in_idle ? off_eff        : off_q;
   assign al_uns  = in_idle ? req_unsigned_i : uns_q;

   data_mem_load_align #(.BITS(BITS), .OFF_W(OFF)) u_align (
      .word_i     (al_word),
      .size_i     (al_size),
      .off_i      (al_off),
      .unsigned_i (al_uns),
      .data_o     (load_val)
   );

   // ---------------- control FSM ----------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         uns_q        <= 1'b0;
         err_q        <= 1'b0;
         size_q       <= SZ_B;
         off_q        <= '0;
         hold_q       <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  we_q        <= req_we_i;
                  uns_q       <= req_unsigned_i;
                  err_q       <= err_d;
                  size_q      <= req_size_i;
                  off_q       <= off_eff;
                  hold_q      <= rd_word;
                  req_ready_q <= 1'b0;
                  if (LATENCY > 1) begin
                     state_q <= WAIT;
                     cnt_q   <= CNT_W'(1);
                  end else begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= err_d;
                     resp_rdata_q <= (req_we_i | err_d) ? '0 : load_val;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == CNT_W'(LATENCY-1)) begin
                  state_q      <= RESP;
                  cnt_q        <= '0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= err_q;
                  resp_rdata_q <= (we_q | err_q) ? '0 : load_val;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: begin
               // No new accept in the retirement cycle: ready rises after.
               if (resp_ready_i) begin
                  state_q      <= IDLE;
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready_o  = req_ready_q;
   assign resp_valid_o = resp_valid_q;
   assign resp_rdata_o = resp_rdata_q;
   assign resp_err_o   = resp_err_q;

endmodule
